// File: rtl/cnn_layer_accel_result_packer.sv
// Packs the quad's 16-bit result stream into multi-lane words with keep/last, buffered by a small word FIFO.
// Optional macro CNL_RESULT_PACKER_RELU_EN clamps negative results to zero before packing.
module cnn_layer_accel_result_packer #(
  parameter int C_RESULT_WIDTH = 16,
  parameter int C_NUM_LANES    = 8,
  parameter int C_FIFO_DEPTH   = 2,
  parameter int C_DIM_W        = 10
) (
  input  logic                                  clk_if,
  input  logic                                  rst,
  input  logic                                  cfg_load,
  input  logic [C_DIM_W-1:0]                    num_output_rows_cfg,
  input  logic [C_DIM_W-1:0]                    num_output_cols_cfg,
  input  logic [C_DIM_W-1:0]                    num_kernel_cfg,
  input  logic                                  result_valid,
  output logic                                  result_accept,
  input  logic [C_RESULT_WIDTH-1:0]             result_data,
  output logic                                  pack_valid,
  input  logic                                  pack_ready,
  output logic [C_RESULT_WIDTH*C_NUM_LANES-1:0] pack_data,
  output logic [C_NUM_LANES-1:0]                pack_keep,
  output logic                                  pack_last,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  cfg_err,
  output logic [1:0]                            dbg_state
);

  localparam int LW = (C_NUM_LANES > 1) ? $clog2(C_NUM_LANES) : 1;
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = C_RESULT_WIDTH * C_NUM_LANES;
  localparam logic [LW-1:0]      C_LAST_LANE = LW'(C_NUM_LANES - 1);
  localparam logic [LW-1:0]      C_LANE_ONE  = LW'(1);
  localparam logic [AW-1:0]      C_PTR_ONE   = AW'(1);
  localparam logic [CW-1:0]      C_CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]      C_CNT_FULL  = CW'(C_FIFO_DEPTH);
  localparam logic [C_DIM_W-1:0] C_DIM_ONE   = C_DIM_W'(1);

  // Handshake: a transfer happens on a rising edge where valid && accept/ready are both high.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t r_state, w_state_nxt;

  logic [C_DIM_W-1:0] r_rows, r_cols, r_kern;
  logic [C_DIM_W-1:0] r_row, r_col, r_dep;
  logic [DW-1:0] r_pack;
  logic [C_NUM_LANES-1:0] r_keep;
  logic [LW-1:0] r_lane_idx;
  logic r_cfg_err;

  logic [DW-1:0] r_fifo_data [C_FIFO_DEPTH];
  logic [C_NUM_LANES-1:0] r_fifo_keep [C_FIFO_DEPTH];
  logic [C_FIFO_DEPTH-1:0] r_fifo_last;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_cfg_bad, w_start, w_xfer, w_final, w_push, w_pop;
  logic [C_RESULT_WIDTH-1:0] w_elem;
  logic [DW-1:0] w_word;
  logic [C_NUM_LANES-1:0] w_keep;

  assign w_cfg_bad = (num_output_rows_cfg == '0) || (num_output_cols_cfg == '0) ||
                     (num_kernel_cfg == '0);
  assign w_start   = (r_state == S_IDLE) && cfg_load && !w_cfg_bad;
  assign result_accept = (r_state == S_RUN) && (r_count < C_CNT_FULL);
  assign w_xfer    = result_valid && result_accept;
  assign w_final   = (r_row == r_rows - C_DIM_ONE) && (r_col == r_cols - C_DIM_ONE) &&
                     (r_dep == r_kern - C_DIM_ONE);
  assign w_push    = w_xfer && ((r_lane_idx == C_LAST_LANE) || w_final);
  assign pack_valid = (r_count != '0);
  assign w_pop     = pack_valid && pack_ready;

`ifdef CNL_RESULT_PACKER_RELU_EN
  assign w_elem = result_data[C_RESULT_WIDTH-1] ? '0 : result_data;
`else
  assign w_elem = result_data;
`endif

  always_comb begin
    w_word = r_pack;
    w_keep = r_keep;
    w_word[r_lane_idx*C_RESULT_WIDTH +: C_RESULT_WIDTH] = w_elem;
    w_keep[r_lane_idx] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_xfer && w_final) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_count == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cfg_err <= 1'b0;
      r_rows    <= '0;
      r_cols    <= '0;
      r_kern    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_err <= (r_state == S_IDLE) && cfg_load && w_cfg_bad;
      if (w_start) begin
        r_rows <= num_output_rows_cfg;
        r_cols <= num_output_cols_cfg;
        r_kern <= num_kernel_cfg;
      end
    end
  end

  // Depth is innermost, then column, then row.
  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
      r_dep <= '0;
    end else if (w_start || (w_xfer && w_final)) begin
      r_row <= '0;
      r_col <= '0;
      r_dep <= '0;
    end else if (w_xfer) begin
      if (r_dep == r_kern - C_DIM_ONE) begin
        r_dep <= '0;
        if (r_col == r_cols - C_DIM_ONE) begin
          r_col <= '0;
          r_row <= r_row + C_DIM_ONE;
        end else begin
          r_col <= r_col + C_DIM_ONE;
        end
      end else begin
        r_dep <= r_dep + C_DIM_ONE;
      end
    end
  end

  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      r_pack     <= '0;
      r_keep     <= '0;
      r_lane_idx <= '0;
    end else if (w_start || w_push) begin
      r_pack     <= '0;
      r_keep     <= '0;
      r_lane_idx <= '0;
    end else if (w_xfer) begin
      r_pack     <= w_word;
      r_keep     <= w_keep;
      r_lane_idx <= r_lane_idx + C_LANE_ONE;
    end
  end

  // Pushes never land on a full FIFO because accept is gated by the count.
  always_ff @(posedge clk_if or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_keep[i] <= '0;
      end
      r_fifo_last <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_word;
        r_fifo_keep[r_wr_ptr] <= w_keep;
        r_fifo_last[r_wr_ptr] <= w_final;
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign pack_data = pack_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign pack_keep = pack_valid ? r_fifo_keep[r_rd_ptr] : '0;
  assign pack_last = pack_valid ? r_fifo_last[r_rd_ptr] : 1'b0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DRAIN) && (r_count == '0);
  assign cfg_err   = r_cfg_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Scoreboard bench for cnn_layer_accel_result_packer; expected words are built as results are driven.
module tb_cnn_layer_accel_result_packer;

  localparam int W  = 16;
  localparam int L  = 8;
  localparam int DW = W * L;
  localparam int EW = DW + L + 1;

  logic clk_if = 1'b0;
  logic rst;
  logic cfg_load;
  logic [9:0] num_output_rows_cfg, num_output_cols_cfg, num_kernel_cfg;
  logic result_valid, result_accept;
  logic [W-1:0] result_data;
  logic pack_valid, pack_ready;
  logic [DW-1:0] pack_data;
  logic [L-1:0] pack_keep;
  logic pack_last, busy, done, cfg_err;
  logic [1:0] dbg_state;

  cnn_layer_accel_result_packer dut (
    .clk_if(clk_if), .rst(rst), .cfg_load(cfg_load),
    .num_output_rows_cfg(num_output_rows_cfg), .num_output_cols_cfg(num_output_cols_cfg),
    .num_kernel_cfg(num_kernel_cfg), .result_valid(result_valid),
    .result_accept(result_accept), .result_data(result_data), .pack_valid(pack_valid),
    .pack_ready(pack_ready), .pack_data(pack_data), .pack_keep(pack_keep),
    .pack_last(pack_last), .busy(busy), .done(done), .cfg_err(cfg_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_if = ~clk_if;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  int n_words = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  stim_q[$];
  logic [EW-1:0] mon_last;
  logic [DW-1:0] m_word;
  logic [L-1:0]  m_keep;
  int            m_lane;
  logic          done_pending = 1'b0;
  logic          hold_v = 1'b0;
  logic [EW-1:0] hold_w;
  logic          stop_rand;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] relu(input logic [W-1:0] x);
`ifdef CNL_RESULT_PACKER_RELU_EN
    return x[W-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // scoreboard monitor: compare each handed-off word, done timing and stall stability
  always @(negedge clk_if) begin
    logic exp_done;
    if (rst) begin
      done_pending = 1'b0;
      hold_v = 1'b0;
    end else begin
      exp_done = done_pending;
      done_pending = 1'b0;
      if (done || exp_done) chk("done", done, exp_done);
      if (hold_v && pack_valid) chk("hold", {pack_last, pack_keep, pack_data}, hold_w);
      hold_v = pack_valid && !pack_ready;
      hold_w = {pack_last, pack_keep, pack_data};
      if (pack_valid && pack_ready) begin
        n_words++;
        mon_last = {pack_last, pack_keep, pack_data};
        if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
        else chk("word", {pack_last, pack_keep, pack_data}, exp_q.pop_front());
        if (pack_last) done_pending = 1'b1;
      end
    end
  end

  task automatic model_clear();
    m_word = '0;
    m_keep = '0;
    m_lane = 0;
  endtask

  // driver: configure, then send n_send results from stim_q; optional cfg_load injected at index inj
  task automatic send_job(input int r, input int c, input int k, input int n_send, input int inj);
    int total;
    logic ok;
    total = r * c * k;
    @(posedge clk_if); #1;
    cfg_load = 1'b1;
    num_output_rows_cfg = 10'(r);
    num_output_cols_cfg = 10'(c);
    num_kernel_cfg = 10'(k);
    @(posedge clk_if); #1;
    cfg_load = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      result_valid = 1'b1;
      result_data = stim_q[i];
      if (i == inj) begin
        cfg_load = 1'b1;
        num_output_rows_cfg = 10'd1;
        num_output_cols_cfg = 10'd1;
        num_kernel_cfg = 10'd1;
      end
      ok = 1'b0;
      for (int t = 0; t < 500 && !ok; t++) begin
        @(negedge clk_if);
        if (result_accept) ok = 1'b1;
        else begin
          @(posedge clk_if); #1;
          cfg_load = 1'b0;
        end
      end
      if (!ok) begin
        chk("accept_timeout", 0, 1);
        result_valid = 1'b0;
        return;
      end
      m_word[m_lane*W +: W] = relu(stim_q[i]);
      m_keep[m_lane] = 1'b1;
      if (m_lane == L - 1 || i == total - 1) begin
        exp_q.push_back({(i == total - 1), m_keep, m_word});
        model_clear();
      end else begin
        m_lane++;
      end
      @(posedge clk_if); #1;
      cfg_load = 1'b0;
      n_xfer++;
    end
    result_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk_if);
      if (!busy && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(negedge clk_if);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_accept"}, result_accept, 0);
    chk({tag, "_pvalid"}, pack_valid, 0);
    chk({tag, "_pdata"}, {pack_last, pack_keep, pack_data}, 0);
    chk({tag, "_busy_done_err"}, {busy, done, cfg_err}, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    logic [EW-1:0] want;
    rst = 1'b1;
    cfg_load = 1'b0;
    num_output_rows_cfg = '0;
    num_output_cols_cfg = '0;
    num_kernel_cfg = '0;
    result_valid = 1'b0;
    result_data = '0;
    pack_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk_if);
    check_reset_outputs("reset");
    @(posedge clk_if); #1;
    rst = 1'b0;

    // single full word 2x2x2, results 1..8
    stim_q.delete();
    for (int i = 1; i <= 8; i++) stim_q.push_back(W'(i));
    fork
      send_job(2, 2, 2, 8, -1);
      begin
        @(posedge clk_if); @(posedge clk_if); @(negedge clk_if);
        chk("busy_rise", busy, 1);
      end
    join
    wait_idle();
    want = '0;
    want[EW-1] = 1'b1;
    want[DW +: L] = 8'hFF;
    for (int i = 0; i < 8; i++) want[i*W +: W] = W'(i + 1);
    chk("full_word", mon_last, want);
    chk("full_no_cfg_err", cfg_err, 0);
    chk("full_idle_state", dbg_state, 0);

    // partial last word with random sink stalls, 17x17x1
    stim_q.delete();
    for (int i = 0; i < 289; i++) stim_q.push_back(W'($urandom_range(0, 65535)));
    n_words = 0;
    stop_rand = 1'b0;
    fork
      begin
        send_job(17, 17, 1, 289, -1);
        wait_idle();
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk_if); #1;
          pack_ready = ($urandom_range(0, 3) != 0);
        end
        pack_ready = 1'b1;
      end
    join
    chk("partial_words", n_words, 37);
    want = '0;
    want[EW-1] = 1'b1;
    want[DW +: L] = 8'h01;
    want[0 +: W] = relu(stim_q[288]);
    chk("partial_last", mon_last, want);

    // backpressure: sink stalled for 30 cycles, 24 results offered
    stim_q.delete();
    for (int i = 0; i < 24; i++) stim_q.push_back(W'($urandom_range(0, 65535)));
    n_xfer = 0;
    pack_ready = 1'b0;
    fork
      send_job(2, 3, 4, 24, -1);
      begin
        repeat (25) @(posedge clk_if);
        @(negedge clk_if);
        chk("bp_xfers", n_xfer, 16);
        chk("bp_accept_low", result_accept, 0);
        chk("bp_pvalid", pack_valid, 1);
        repeat (5) @(posedge clk_if);
        #1 pack_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_total", n_xfer, 24);

    // sign clamp option
    stim_q.delete();
    stim_q.push_back(16'hFFFB);
    stim_q.push_back(16'h0007);
    send_job(1, 1, 2, 2, -1);
    wait_idle();
    want = '0;
    want[EW-1] = 1'b1;
    want[DW +: L] = 8'h03;
`ifdef CNL_RESULT_PACKER_RELU_EN
    want[0 +: W] = 16'h0000;
`else
    want[0 +: W] = 16'hFFFB;
`endif
    want[W +: W] = 16'h0007;
    chk("relu_word", mon_last, want);

    // reset mid-job after 5 of 8 results
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(16'hA000 + W'(i));
    send_job(2, 2, 2, 5, -1);
    rst = 1'b1;
    exp_q.delete();
    model_clear();
    @(negedge clk_if);
    check_reset_outputs("midrst");
    @(posedge clk_if); #1;
    rst = 1'b0;
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(16'h0B00 + W'(i));
    n_words = 0;
    send_job(2, 2, 2, 8, -1);
    wait_idle();
    want = '0;
    want[EW-1] = 1'b1;
    want[DW +: L] = 8'hFF;
    for (int i = 0; i < 8; i++) want[i*W +: W] = 16'h0B00 + W'(i);
    chk("after_rst_word", mon_last, want);
    chk("after_rst_count", n_words, 1);

    // config error: kernels = 0
    @(posedge clk_if); #1;
    cfg_load = 1'b1;
    num_output_rows_cfg = 10'd3;
    num_output_cols_cfg = 10'd3;
    num_kernel_cfg = 10'd0;
    @(posedge clk_if); #1;
    cfg_load = 1'b0;
    @(negedge clk_if);
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_state", dbg_state, 0);
    chk("cfg_err_accept", result_accept, 0);
    @(negedge clk_if);
    chk("cfg_err_once", cfg_err, 0);
    chk("cfg_err_busy", busy, 0);

    // cfg_load during RUN is ignored
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(W'($urandom_range(0, 32767)));
    n_words = 0;
    send_job(2, 2, 2, 8, 3);
    wait_idle();
    chk("run_cfg_words", n_words, 1);
    chk("run_cfg_keep", mon_last[EW-1 -: L+1], 9'h1FF);
    chk("run_cfg_no_err", cfg_err, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
